fsm_ti_trigger: RTL

Parametrised, reconfigurable trigger/payload unit for Trojan-instrumented FSM benchmarks. It sits between a host FSM's next-state logic and its state register. It counts visits to up to NCH configurable trigger states. Once a channel's count condition is met, it substitutes that channel's target state for the host's next state, in one-shot, periodic or ordered-sequence mode. Counting is fully registered, so counts advance exactly once per host state transition.

---
 rtl/fsm_ti_trigger_pkg.sv | 16 +
 rtl/fsm_ti_trigger_if.sv | 29 ++
 rtl/fsm_ti_trigger_chan.sv | 100 ++++++++++
 rtl/fsm_ti_trigger.sv | 102 ++++++++++
 4 files changed

// File: rtl/fsm_ti_trigger_pkg.sv
// Shared mode encodings and default widths for the FSM trigger/payload unit.
package fsm_ti_pkg;
    localparam int TI_ONESHOT  = 0;
    localparam int TI_PERIODIC = 1;
    localparam int TI_SEQUENCE = 2;

    localparam int TI_SW_DEF  = 5;
    localparam int TI_NCH_DEF = 4;
    localparam int TI_CW_DEF  = 4;

    typedef enum logic [1:0] {
        M_ONESHOT  = 2'd0,
        M_PERIODIC = 2'd1,
        M_SEQUENCE = 2'd2
    } ti_mode_e;
endpackage

// File: rtl/fsm_ti_trigger_if.sv
// Host-side bus of the trigger unit: state taps, channel config port and payload outputs.
interface fsm_ti_trigger_if #(
    parameter int SW  = 5,
    parameter int NCH = 4,
    parameter int CW  = 4
);
    logic                     en;
    logic                     step;
    logic [SW-1:0]            pr_state;
    logic [SW-1:0]            nx_state;
    logic                     cfg_we;
    logic [$clog2(NCH)-1:0]   cfg_ch;
    logic [SW-1:0]            cfg_state;
    logic [CW-1:0]            cfg_thresh;
    logic [SW-1:0]            cfg_target;
    logic [SW-1:0]            nx_state_o;
    logic [NCH-1:0]           fired;
    logic                     armed;
    logic [CW-1:0]            cnt_o;

    modport master (
        output en, step, pr_state, nx_state, cfg_we, cfg_ch, cfg_state, cfg_thresh, cfg_target,
        input  nx_state_o, fired, armed, cnt_o
    );
    modport slave (
        input  en, step, pr_state, nx_state, cfg_we, cfg_ch, cfg_state, cfg_thresh, cfg_target,
        output nx_state_o, fired, armed, cnt_o
    );
endinterface

// File: rtl/fsm_ti_trigger_chan.sv
// One trigger channel: config registers, state match, hit counter, redirect and fired flag.
module fsm_ti_chan
    import fsm_ti_pkg::*;
#(
    parameter int SW = 5,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  ti_mode_e      i_mode,
    input  logic          i_en,
    input  logic          i_step,
    input  logic [SW-1:0] i_pr_state,
    input  logic          i_cfg_we,
    input  logic [SW-1:0] i_cfg_state,
    input  logic [CW-1:0] i_cfg_thresh,
    input  logic [SW-1:0] i_cfg_target,
    input  logic          i_is_current,
    input  logic          i_seq_clear,
    input  logic          i_armed,
    output logic          o_hit,
    output logic          o_redir,
    output logic          o_last,
    output logic          o_valid,
    output logic          o_fired,
    output logic [SW-1:0] o_target,
    output logic [CW-1:0] o_cnt
);
    logic [SW-1:0] r_trig;
    logic [CW-1:0] r_thresh;
    logic [SW-1:0] r_target;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    logic          r_fired;

    // One extra bit so a threshold of all-ones never wraps the compare
    logic [CW:0]   w_cnt1;
    logic [CW:0]   w_thr1;
    logic          w_redir;

    assign w_cnt1   = {1'b0, r_cnt} + 1'b1;
    assign w_thr1   = {1'b0, r_thresh};
    assign o_hit    = i_en & i_step & r_valid & (i_pr_state == r_trig);
    assign o_last   = (w_cnt1 == w_thr1);
    assign o_redir  = w_redir;
    assign o_valid  = r_valid;
    assign o_fired  = r_fired;
    assign o_target = r_target;
    assign o_cnt    = r_cnt;

    always_comb begin
        w_redir = 1'b0;
        case (i_mode)
            M_ONESHOT:  w_redir = o_hit & (w_cnt1 >= w_thr1);
            M_PERIODIC: w_redir = o_hit & o_last;
            M_SEQUENCE: w_redir = o_hit & i_armed;
            default:    w_redir = 1'b0;
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_trig   <= '0;
            r_thresh <= '0;
            r_target <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_fired  <= 1'b0;
        end else if (i_cfg_we) begin
            r_trig   <= i_cfg_state;
            r_thresh <= i_cfg_thresh;
            r_target <= i_cfg_target;
            r_cnt    <= '0;
            r_valid  <= (i_cfg_thresh != '0);
            r_fired  <= 1'b0;
        end else begin
            case (i_mode)
                M_ONESHOT: begin
                    if (o_hit)
                        r_cnt <= (w_cnt1 >= w_thr1) ? r_thresh : w_cnt1[CW-1:0];
                    if (w_redir)
                        r_fired <= 1'b1;
                end
                M_PERIODIC: begin
                    r_fired <= w_redir;
                    if (o_hit)
                        r_cnt <= w_redir ? '0 : w_cnt1[CW-1:0];
                end
                M_SEQUENCE: begin
                    // Ordering violation clears every channel, even one that also matched
                    if (i_seq_clear)
                        r_cnt <= '0;
                    else if (o_hit && i_is_current)
                        r_cnt <= w_cnt1[CW-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fsm_ti_trigger.sv
// Trigger/payload unit between a host FSM's next-state logic and its state register.
module fsm_ti_trigger
    import fsm_ti_pkg::*;
#(
    parameter int SW   = TI_SW_DEF,
    parameter int NCH  = TI_NCH_DEF,
    parameter int CW   = TI_CW_DEF,
    parameter int MODE = TI_ONESHOT
) (
    input  logic            clk,
    input  logic            rst,
    fsm_ti_trigger_if.slave bus
);
    localparam int CHW = $clog2(NCH);
    localparam int PW  = $clog2(NCH) + 1;
    localparam ti_mode_e L_MODE = ti_mode_e'(MODE[1:0]);

    logic [NCH-1:0]         w_hit, w_redir, w_last, w_valid, w_fired;
    logic [NCH-1:0]         w_is_cur;
    logic [NCH-1:0][SW-1:0] w_target;
    logic [NCH-1:0][CW-1:0] w_cnt;

    logic [PW-1:0] r_seq_ptr;
    logic          r_armed;
    logic [PW-1:0] w_cur;
    logic          w_found, w_more, w_viol, w_done, w_seq_act, w_seq_clear;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign w_is_cur[g] = w_seq_act & w_found & (w_cur == PW'(g));

        fsm_ti_chan #(.SW(SW), .CW(CW)) u_chan (
            .clk          (clk),
            .rst          (rst),
            .i_mode       (L_MODE),
            .i_en         (bus.en),
            .i_step       (bus.step),
            .i_pr_state   (bus.pr_state),
            .i_cfg_we     (bus.cfg_we && (bus.cfg_ch == CHW'(g))),
            .i_cfg_state  (bus.cfg_state),
            .i_cfg_thresh (bus.cfg_thresh),
            .i_cfg_target (bus.cfg_target),
            .i_is_current (w_is_cur[g]),
            .i_seq_clear  (w_seq_clear),
            .i_armed      (r_armed),
            .o_hit        (w_hit[g]),
            .o_redir      (w_redir[g]),
            .o_last       (w_last[g]),
            .o_valid      (w_valid[g]),
            .o_fired      (w_fired[g]),
            .o_target     (w_target[g]),
            .o_cnt        (w_cnt[g])
        );
    end

    // Lowest-index redirecting channel supplies the payload state
    always_comb begin
        bus.nx_state_o = bus.nx_state;
        for (int c = NCH - 1; c >= 0; c--)
            if (w_redir[c]) bus.nx_state_o = w_target[c];
    end

    assign bus.cnt_o = w_cnt[bus.cfg_ch];
    assign bus.armed = r_armed;
    assign bus.fired = (L_MODE == M_SEQUENCE) ? {NCH{r_armed}} : w_fired;

    // Sequence tracking: the current channel is the first valid one at or above seq_ptr
    assign w_seq_act   = (L_MODE == M_SEQUENCE) & ~r_armed;
    assign w_seq_clear = w_seq_act & w_viol;

    always_comb begin
        w_found = 1'b0;
        w_cur   = '0;
        w_done  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (!w_found && w_valid[c] && (c >= int'(r_seq_ptr))) begin
                w_found = 1'b1;
                w_cur   = PW'(c);
                w_done  = w_hit[c] & w_last[c];
            end
        end
        w_more = 1'b0;
        w_viol = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (w_valid[c] && (c > int'(w_cur))) w_more = 1'b1;
            if (w_hit[c] && (!w_found || (w_cur != PW'(c)))) w_viol = 1'b1;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_seq_ptr <= '0;
            r_armed   <= 1'b0;
        end else if (w_seq_act) begin
            if (w_viol) begin
                r_seq_ptr <= '0;
            end else if (w_done) begin
                r_seq_ptr <= w_cur + 1'b1;
                if (!w_more) r_armed <= 1'b1;
            end
        end
    end
endmodule
